// File: rtl/wm_timed_ctrl.sv
// Timed wash-cycle sequencer for one drum: IDLE -> WASH -> RINSE (xN) -> SPIN -> IDLE.
// Pause or an open lid freezes the running phase and gates the motor/valve enables.
module wm_timed_ctrl #(
  parameter int TIMER_W   = 16,
  parameter int WASH_CYC  = 100,
  parameter int RINSE_CYC = 60,
  parameter int SPIN_CYC  = 80,
  parameter int RINSE_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [RINSE_W-1:0] num_rinses,
  input  logic               lid_closed,
  input  logic               pause,
  output logic               wash,
  output logic               rinse,
  output logic               spin,
  output logic               busy,
  output logic               done,
  output logic [1:0]         phase,
  output logic [TIMER_W-1:0] time_left
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WASH  = 2'd1,
    S_RINSE = 2'd2,
    S_SPIN  = 2'd3
  } state_t;

  // Timers count down to zero, so each phase loads its length minus one.
  localparam logic [TIMER_W-1:0] WASH_LD  = TIMER_W'(WASH_CYC - 1);
  localparam logic [TIMER_W-1:0] RINSE_LD = TIMER_W'(RINSE_CYC - 1);
  localparam logic [TIMER_W-1:0] SPIN_LD  = TIMER_W'(SPIN_CYC - 1);

  state_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [RINSE_W-1:0]   rinses, rinses_nxt;
  logic                 done_nxt;
  logic                 hold;

  assign hold = pause | ~lid_closed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      timer  <= '0;
      rinses <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      rinses <= rinses_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    rinses_nxt = rinses;
    done_nxt   = 1'b0;
    if (state == S_IDLE) begin
      if (start && !hold) begin
        state_nxt  = S_WASH;
        timer_nxt  = WASH_LD;
        rinses_nxt = num_rinses;
      end
    end else if (!hold) begin
      if (timer != '0) begin
        timer_nxt = timer - TIMER_W'(1);
      end else begin
        case (state)
          S_WASH, S_RINSE: begin
            // Outstanding rinse passes take priority over moving on to spin.
            if (rinses != '0) begin
              state_nxt  = S_RINSE;
              timer_nxt  = RINSE_LD;
              rinses_nxt = rinses - RINSE_W'(1);
            end else begin
              state_nxt = S_SPIN;
              timer_nxt = SPIN_LD;
            end
          end
          default: begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
            done_nxt  = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    wash      = (state == S_WASH)  && !hold;
    rinse     = (state == S_RINSE) && !hold;
    spin      = (state == S_SPIN)  && !hold;
    busy      = (state != S_IDLE);
    phase     = state;
    time_left = timer;
  end

endmodule
